// File: rtl/pop_acc_if.sv
// rtl/pop_acc_if.sv - beat input and frame-total output handshakes of pop_acc
interface pop_acc_if #(
    parameter int IN    = 8,
    parameter int FRAME = 4,
    parameter int ACC_W = 4
);
    localparam int BW = $clog2(FRAME + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN-1:0]    in;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out;
    logic [BW-1:0]    out_beats;
    logic             ovf;

    modport slave (
        input  in_valid, in, in_last, out_ready,
        output in_ready, out_valid, out, out_beats, ovf
    );

    modport master (
        output in_valid, in, in_last, out_ready,
        input  in_ready, out_valid, out, out_beats, ovf
    );
endinterface

// File: rtl/pop_acc.sv
// rtl/pop_acc.sv - frame-based population-count accumulator
// Optional POP_ACC_SAT_EN: saturate the accumulator instead of wrapping.
module pop_acc #(
    parameter int IN    = 8,
    parameter bit ACT   = 1'b1,
    parameter int FRAME = 4,
    parameter int ACC_W = 4
) (
    input logic        clk,
    input logic        reset,
    pop_acc_if.slave   bus
);
    localparam int CW = $clog2(IN) + 1;
    localparam int BW = $clog2(FRAME + 1);
    // Wide enough that acc + count can never lose a carry.
    localparam int SW = ACC_W + CW;
    localparam logic [SW-1:0] MAX = {{CW{1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic {ACC, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] out_q;
    logic [BW-1:0]    beats;
    logic [BW-1:0]    beats_inc;
    logic [BW-1:0]    beats_q;
    logic             ovf_q;
    logic             accept;
    logic             frame_end;
    logic             in_ready;
    logic             out_valid;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < IN; i++) begin
            cnt = cnt + CW'(bus.in[i] == ACT);
        end
    end

    assign sum     = SW'(acc) + SW'(cnt);
    assign sum_ovf = sum > MAX;

`ifdef POP_ACC_SAT_EN
    assign acc_nxt = sum_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    assign beats_inc = beats + 1'b1;
    assign accept    = in_ready & bus.in_valid;
    assign frame_end = bus.in_last | (beats_inc == BW'(FRAME));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (accept && frame_end) state_nxt = HOLD;
            HOLD:    if (bus.out_ready)       state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC:     in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            beats   <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            beats_q <= '0;
        end else if (accept) begin
            acc   <= acc_nxt;
            beats <= beats_inc;
            ovf_q <= ovf_q | sum_ovf;
            if (frame_end) begin
                out_q   <= acc_nxt;
                beats_q <= beats_inc;
            end
        end else if (out_valid && bus.out_ready) begin
            acc   <= '0;
            beats <= '0;
            ovf_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out       = out_q;
    assign bus.out_beats = beats_q;
    assign bus.ovf       = ovf_q;
endmodule
